// File: rtl/serial_display_arbiter.sv
// serial_display_arbiter
// One serial shift engine shared by three display targets (LED bank,
// 7-segment, LCD). A requester is granted round-robin. Its word is shifted
// out MSB-first on a single data line. The owning target's latch line then
// pulses for one cycle, and an optional idle gap follows before the next
// grant. Every output comes straight from a flop.

module serial_display_arbiter #(
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic [2:0]        i_Req,
  input  logic [DATA_W-1:0] i_Data0,
  input  logic [DATA_W-1:0] i_Data1,
  input  logic [DATA_W-1:0] i_Data2,
  output logic [2:0]        o_Ack,
  output logic              o_SerData,
  output logic [2:0]        o_Latch,
  output logic              o_Busy,
  output logic [1:0]        o_Owner
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Next requester after 'last', scanning upward with wrap. The result is
  // only used when at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] pick;
    case (last)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
    if (req[p0]) begin
      pick = p0;
    end else if (req[p1]) begin
      pick = p1;
    end else begin
      pick = p2;
    end
    return pick;
  endfunction

  // Requester index to its one-hot ack/latch line.
  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  state_t            state_r;
  state_t            state_s;
  // Holds the bits still to be sent below the one already on the data line.
  logic [DATA_W-2:0] shift_r;
  logic [DATA_W-2:0] shift_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_s;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_s;
  logic [1:0]        owner_r;
  logic [1:0]        owner_s;
  logic [2:0]        ack_r;
  logic [2:0]        ack_s;
  logic [2:0]        latch_r;
  logic [2:0]        latch_s;
  logic              ser_r;
  logic              ser_s;
  logic              busy_r;
  logic              busy_s;
  logic [1:0]        sel_s;
  logic [DATA_W-1:0] sel_word_s;

  // Pick the round-robin winner and route its data word.
  always_comb begin
    sel_s = rr_pick(i_Req, owner_r);
    case (sel_s)
      2'd0:    sel_word_s = i_Data0;
      2'd1:    sel_word_s = i_Data1;
      default: sel_word_s = i_Data2;
    endcase
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    owner_s   = owner_r;
    ack_s     = 3'b000;
    latch_s   = 3'b000;
    ser_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_Req != 3'b000) begin
          // Grant edge: the MSB goes on the line at once and the rest waits.
          state_s   = ST_SHIFT;
          shift_s   = sel_word_s[DATA_W-2:0];
          ser_s     = sel_word_s[DATA_W-1];
          bit_cnt_s = CNT_W'(DATA_W - 1);
          owner_s   = sel_s;
          ack_s     = to_onehot(sel_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r == '0) begin
          state_s = ST_LATCH;
          latch_s = to_onehot(owner_r);
        end else begin
          ser_s     = shift_r[DATA_W-2];
          shift_s   = shift_r << 1;
          bit_cnt_s = bit_cnt_r - CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (GAP_CYCLES > 0) begin
          state_s   = ST_GAP;
          gap_cnt_s = GAP_W'(GAP_CYCLES - 1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers. Reset aborts any transfer without a latch.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      owner_r   <= 2'd2;
      ack_r     <= 3'b000;
      latch_r   <= 3'b000;
      ser_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      owner_r   <= owner_s;
      ack_r     <= ack_s;
      latch_r   <= latch_s;
      ser_r     <= ser_s;
      busy_r    <= busy_s;
    end
  end

  assign o_Ack     = ack_r;
  assign o_SerData = ser_r;
  assign o_Latch   = latch_r;
  assign o_Busy    = busy_r;
  assign o_Owner   = owner_r;

endmodule

// File: tb/tb_serial_display_arbiter.sv
// Bench for serial_display_arbiter. The stimulus drives requests and data.
// A reference model decides at each clock edge whether a grant happens:
// the first requester after the last owner is chosen, and the engine is
// free again one transfer period later. Each grant is pushed onto a
// scoreboard. A separate monitor pops the scoreboard on every ack and
// checks the serial word, the latch pulse and the busy line. A second
// instance with an 8-bit word and no gap gets a short directed check.
module tb_serial_display_arbiter;

  localparam int DW  = 16;
  localparam int GAP = 2;
  localparam int PER = DW + GAP + 2;

  typedef struct {
    int          id;
    logic [15:0] word;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req;
  logic [15:0] d0, d1, d2;
  logic [2:0]  ack, latch;
  logic        ser, busy;
  logic [1:0]  owner;

  logic [2:0]  req2;
  logic [7:0]  e0, e1, e2;
  logic [2:0]  ack2, latch2;
  logic        ser2, busy2;
  logic [1:0]  owner2;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          n_exp = 0;
  int          n_obs = 0;
  int          cyc = 0;
  int          last_m = 2;
  int          next_grant = 0;
  logic [2:0]  cont = 3'b000;

  serial_display_arbiter #(.DATA_W(16), .GAP_CYCLES(2)) u_dut (
    .i_CLK(clk), .i_RESET(rst), .i_Req(req),
    .i_Data0(d0), .i_Data1(d1), .i_Data2(d2),
    .o_Ack(ack), .o_SerData(ser), .o_Latch(latch), .o_Busy(busy), .o_Owner(owner)
  );

  serial_display_arbiter #(.DATA_W(8), .GAP_CYCLES(0)) u_dut2 (
    .i_CLK(clk), .i_RESET(rst), .i_Req(req2),
    .i_Data0(e0), .i_Data1(e1), .i_Data2(e2),
    .o_Ack(ack2), .o_SerData(ser2), .o_Latch(latch2), .o_Busy(busy2), .o_Owner(owner2)
  );

  always #5 clk = ~clk;

  // Edge index: value before an edge is that edge's number since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input int i);
    logic [2:0] v;
    v = 3'b000;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] word_of(input int i);
    if (i == 0) return d0;
    else if (i == 1) return d1;
    else return d2;
  endfunction

  task automatic set_word(input int i, input logic [15:0] w);
    if (i == 0) d0 = w;
    else if (i == 1) d1 = w;
    else d2 = w;
  endtask

  // Reference model for the upcoming edge, then advance to the next negedge.
  task automatic tick();
    int sel;
    int c;
    sel = -1;
    if (cyc >= next_grant && req != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        c = (last_m + k) % 3;
        if (sel < 0 && req[c]) sel = c;
      end
      exp_q.push_back('{sel, word_of(sel), cyc});
      n_exp++;
      last_m = sel;
      next_grant = cyc + PER;
    end
    @(negedge clk);
    if (sel >= 0) begin
      if (!cont[sel]) req[sel] = 1'b0;
      if ($urandom_range(0, 1) == 1) set_word(sel, 16'($urandom));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", ack, 3'b000);
    check("rst_latch", latch, 3'b000);
    check("rst_ser", ser, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 2'd2);
  endtask

  // Asynchronous reset applied mid-cycle; outputs checked right away.
  task automatic reset_dut();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    req = 3'b000;
    exp_q.delete();
    last_m = 2;
    next_grant = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: consume an expected transfer per ack and check its whole frame.
  initial begin
    int          phase;
    exp_t        cur;
    logic [15:0] bits;
    phase = -1;
    bits = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        phase = -1;
      end else begin
        if (ack !== 3'b000) begin
          if (phase >= 0) begin
            check("ack_while_busy", ack, 3'b000);
          end else if (exp_q.size() == 0) begin
            check("unexpected_ack", ack, 3'b000);
          end else begin
            cur = exp_q.pop_front();
            n_obs++;
            check("ack_onehot", ack, onehot(cur.id));
            check("owner", owner, cur.id);
            check("grant_cycle", cyc, cur.cyc + 1);
            phase = 0;
            bits = 16'h0000;
          end
        end
        if (phase >= 0) begin
          check("busy", busy, 1'b1);
          if (phase < DW) begin
            bits = {bits[14:0], ser};
            check("latch_in_shift", latch, 3'b000);
            if (phase == DW - 1) check("serial_word", bits, cur.word);
          end else if (phase == DW) begin
            check("latch", latch, onehot(cur.id));
            check("ser_latch", ser, 1'b0);
          end else begin
            check("latch_gap", latch, 3'b000);
            check("ser_gap", ser, 1'b0);
          end
          phase++;
          if (phase > DW + GAP) phase = -1;
        end else begin
          check("idle_busy", busy, 1'b0);
          check("idle_latch", latch, 3'b000);
          check("idle_ser", ser, 1'b0);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [7:0] w2;
    req = 3'b000; d0 = 16'h0000; d1 = 16'h0000; d2 = 16'h0000;
    req2 = 3'b000; e0 = 8'h00; e1 = 8'h00; e2 = 8'h00;
    repeat (2) @(posedge clk);
    #2 check_reset_outputs();
    check("rst2_busy", busy2, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single LED transfer.
    d0 = 16'hA5C3; req = 3'b001;
    run(25);

    // All three from reset.
    reset_dut();
    d0 = 16'h0001; d1 = 16'h8000; d2 = 16'hFFFF; req = 3'b111;
    run(65);

    // SEG and LCD held continuously.
    cont = 3'b110; req = 3'b110;
    run(6 * PER);
    req = 3'b000; cont = 3'b000;
    run(PER);

    // LED raised and withdrawn during a SEG transfer; SEG data changed mid-shift.
    d1 = 16'($urandom); req = 3'b010;
    run(3);
    req[0] = 1'b1; d0 = 16'($urandom);
    run(5);
    d1 = ~d1;
    run(5);
    req[0] = 1'b0;
    run(PER);

    // Random traffic with raises and withdrawals.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_word(i, 16'($urandom));
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    req = 3'b000;
    run(PER + 2);

    // Reset in the middle of an LED shift, then priority restarts at 0.
    d0 = 16'($urandom); req = 3'b001;
    run(7);
    reset_dut();
    d0 = 16'($urandom); d1 = 16'($urandom); req = 3'b011;
    run(2 * PER + 2);

    // 8-bit, no-gap instance: back-to-back LCD at a 10-cycle period.
    w2 = 8'h5A;
    e2 = w2;
    req2 = 3'b100;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check("g0_latch", latch2, (c == 9 || c == 19) ? 3'b100 : 3'b000);
      check("g0_busy", busy2, (c == 10 || c == 20) ? 1'b0 : 1'b1);
      if (c == 1 || c == 11 || c == 21) begin
        check("g0_ack", ack2, 3'b100);
        check("g0_owner", owner2, 2'd2);
      end
      if (c >= 1 && c <= 8) check("g0_ser_a", ser2, w2[8 - c]);
      if (c >= 11 && c <= 18) check("g0_ser_b", ser2, w2[18 - c]);
    end
    req2 = 3'b000;
    repeat (12) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    check("transfer_count", n_obs, n_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
